// File: rtl/vscale_csr_arbiter.sv
// vscale_csr_arbiter: shares the single CSR-file port between core CSR instructions and HTIF PCR requests.
// Define CSR_ARB_STARVE_EN to bound how long continuous core traffic may hold off a queued host request.

`ifndef CSR_ADDR_WIDTH
`define CSR_ADDR_WIDTH 12
`endif
`ifndef CSR_CMD_WIDTH
`define CSR_CMD_WIDTH 3
`endif
`ifndef XPR_LEN
`define XPR_LEN 32
`endif
`ifndef HTIF_PCR_WIDTH
`define HTIF_PCR_WIDTH 64
`endif
`ifndef CSR_IDLE
`define CSR_IDLE 3'd0
`endif
`ifndef CSR_READ
`define CSR_READ 3'd4
`endif
`ifndef CSR_WRITE
`define CSR_WRITE 3'd5
`endif
`ifndef CSR_SET
`define CSR_SET 3'd6
`endif
`ifndef CSR_CLEAR
`define CSR_CLEAR 3'd7
`endif

module vscale_csr_arbiter #(
    parameter int MAX_CORE_WAIT = 4,
    parameter int WAIT_CNT_W    = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         core_req,
    input  logic [`CSR_ADDR_WIDTH-1:0]   core_addr,
    input  logic [`CSR_CMD_WIDTH-1:0]    core_cmd,
    input  logic [`XPR_LEN-1:0]          core_wdata,
    output logic                         core_gnt,
    output logic [`XPR_LEN-1:0]          core_rdata,
    output logic                         core_illegal,
    input  logic                         host_req_valid,
    output logic                         host_req_ready,
    input  logic                         host_req_rw,
    input  logic [`CSR_ADDR_WIDTH-1:0]   host_req_addr,
    input  logic [`HTIF_PCR_WIDTH-1:0]   host_req_data,
    output logic                         host_resp_valid,
    input  logic                         host_resp_ready,
    output logic [`HTIF_PCR_WIDTH-1:0]   host_resp_data,
    output logic                         csr_req,
    output logic [`CSR_ADDR_WIDTH-1:0]   csr_addr,
    output logic [`CSR_CMD_WIDTH-1:0]    csr_cmd,
    output logic [`XPR_LEN-1:0]          csr_wdata,
    input  logic [`XPR_LEN-1:0]          csr_rdata,
    input  logic                         csr_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            host_rw_q, host_rw_d;
    logic [`CSR_ADDR_WIDTH-1:0]      host_addr_q, host_addr_d;
    logic [31:0]                     host_data_q, host_data_d;
    logic                            req_ready_q, req_ready_d;
    logic                            resp_valid_q, resp_valid_d;
    logic [`HTIF_PCR_WIDTH-1:0]      resp_data_q, resp_data_d;
    logic                            host_issue_s;
    logic                            starve_s;
    logic                            unused_s;

    // Response word seen by the host: illegal flag just above the low 32 data bits.
    function automatic logic [`HTIF_PCR_WIDTH-1:0] pack_resp(input logic illegal,
                                                             input logic [`XPR_LEN-1:0] rdata);
        pack_resp = {31'b0, illegal, rdata[31:0]};
    endfunction

`ifdef CSR_ARB_STARVE_EN
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    assign starve_s = (wait_cnt_q == WAIT_CNT_W'(MAX_CORE_WAIT));
    assign unused_s = ^host_req_data[`HTIF_PCR_WIDTH-1:32];

    // Count core grants that overtake a waiting host request.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_ISSUE) begin
            if (host_issue_s) begin
                wait_cnt_d = {WAIT_CNT_W{1'b0}};
            end else if (core_gnt && !starve_s) begin
                wait_cnt_d = wait_cnt_q + {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = {WAIT_CNT_W{1'b0}};
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= {WAIT_CNT_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign starve_s = 1'b0;
    assign unused_s = ^{host_req_data[`HTIF_PCR_WIDTH-1:32], WAIT_CNT_W'(MAX_CORE_WAIT)};
`endif

    // Host takes the port when the core is quiet, or when the core has had its fill.
    always_comb begin
        host_issue_s = 1'b0;
        if (state_q == ST_ISSUE) begin
            host_issue_s = !core_req || starve_s;
        end else begin
            host_issue_s = 1'b0;
        end
    end

    // CSR port mux; the core path is zero-latency and mirrors core_* when idle.
    always_comb begin
        core_gnt  = 1'b0;
        csr_req   = 1'b0;
        csr_addr  = core_addr;
        csr_cmd   = core_cmd;
        csr_wdata = core_wdata;
        if (host_issue_s) begin
            csr_req   = 1'b1;
            csr_addr  = host_addr_q;
            csr_cmd   = host_rw_q ? `CSR_WRITE : `CSR_READ;
            csr_wdata = host_data_q;
        end else begin
            core_gnt  = core_req;
            csr_req   = core_req;
        end
    end

    assign core_rdata      = csr_rdata;
    assign core_illegal    = csr_illegal & core_gnt;
    assign host_req_ready  = req_ready_q;
    assign host_resp_valid = resp_valid_q;
    assign host_resp_data  = resp_data_q;

    // Host transaction sequencing: accept, issue, respond.
    always_comb begin
        state_d     = state_q;
        host_rw_d   = host_rw_q;
        host_addr_d = host_addr_q;
        host_data_d = host_data_q;
        resp_data_d = resp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (host_req_valid) begin
                    state_d     = ST_ISSUE;
                    host_rw_d   = host_req_rw;
                    host_addr_d = host_req_addr;
                    host_data_d = host_req_data[31:0];
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (host_issue_s) begin
                    state_d     = ST_RESP;
                    resp_data_d = pack_resp(csr_illegal, csr_rdata);
                end else begin
                    state_d     = ST_ISSUE;
                end
            end
            ST_RESP: begin
                if (host_resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State, latched host request and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            host_rw_q    <= 1'b0;
            host_addr_q  <= {`CSR_ADDR_WIDTH{1'b0}};
            host_data_q  <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= {`HTIF_PCR_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            host_rw_q    <= host_rw_d;
            host_addr_q  <= host_addr_d;
            host_data_q  <= host_data_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule
